// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: round-robin arbiter for NUM_REQ requesters with a
// programmable time slice. The arbiter skips idle requesters, and it releases a
// grant early when the owner drops its request. Every output is registered.
//
// Optional build macro: RR_ARB_LOCK_EN adds the `lock` input. While lock is
// high, quantum expiry is held off.
//
// Ports:
//   clk            system clock; all logic is clocked on posedge
//   reset          synchronous, active-high reset
//   request_queue  level-sensitive request bit per requester
//   lock           (RR_ARB_LOCK_EN only) holds the current grant past its quantum
//   grant_out      one-hot grant, or zero when idle
//   grant_valid    high when grant_out is nonzero
//   grant_idx      binary index of the owner; zero when idle
//   slice_expire   one-cycle pulse after a grant ends by quantum expiry
module rr_arbiter_param #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned SLICE_CYCLES = 150000000,
    parameter int unsigned CNT_W        = 32,
    localparam int unsigned IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] request_queue,
`ifdef RR_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] grant_out,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               slice_expire
);

    localparam int unsigned     PW       = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 expire_q, expire_d;

    logic                 lock_c;
    logic                 drop_c;
    logic                 expiry_c;
    logic [IDX_W-1:0]     next_ptr_c;
    logic [PW-1:0]        pick_c;

`ifdef RR_ARB_LOCK_EN
    assign lock_c = lock;
`else
    assign lock_c = 1'b0;
`endif

    // First requester in the order start, start+1, ..., wrapping at NUM_REQ.
    // The result is {found, index}.
    function automatic logic [PW-1:0] pick(input logic [NUM_REQ-1:0] req,
                                           input logic [IDX_W-1:0]   start);
        logic             found;
        logic [IDX_W-1:0] win;
        logic [PW-1:0]    pos;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, start} + PW'(i);
            if (pos >= PW'(NUM_REQ)) begin
                pos = pos - PW'(NUM_REQ);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = pos[IDX_W-1:0];
            end
        end
        return {found, win};
    endfunction

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            expire_q <= expire_d;
        end
    end

    // Next-state: arbitration, slice counting and release/handoff
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        expire_d   = 1'b0;
        drop_c     = 1'b0;
        expiry_c   = 1'b0;
        next_ptr_c = ptr_q;
        pick_c     = '0;

        unique case (state_q)
            ST_IDLE: begin
                pick_c = pick(request_queue, ptr_q);
                cnt_d  = '0;
                if (pick_c[IDX_W]) begin
                    state_d = ST_GRANT;
                    grant_d = NUM_REQ'(1) << pick_c[IDX_W-1:0];
                    idx_d   = pick_c[IDX_W-1:0];
                    valid_d = 1'b1;
                end else begin
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end
            end

            ST_GRANT: begin
                drop_c   = !request_queue[idx_q];
                // While locked, the counter sits at CNT_LAST and does not expire.
                expiry_c = (cnt_q == CNT_LAST) && !lock_c;
                if (!drop_c && !expiry_c) begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    next_ptr_c = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                : idx_q + IDX_W'(1);
                    ptr_d    = next_ptr_c;
                    pick_c   = pick(request_queue, next_ptr_c);
                    // A request drop takes precedence, so only a pure expiry pulses.
                    expire_d = !drop_c;
                    cnt_d    = '0;
                    if (pick_c[IDX_W]) begin
                        grant_d = NUM_REQ'(1) << pick_c[IDX_W-1:0];
                        idx_d   = pick_c[IDX_W-1:0];
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_out    = grant_q;
    assign grant_valid  = valid_q;
    assign grant_idx    = idx_q;
    assign slice_expire = expire_q;

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- Parametrised round-robin arbiter for NUM_REQ requesters with a programmable time slice (quantum).
- Work-conserving: idle requesters are skipped, and a grant is released early when its owner drops its request.
- Outputs are registered: one-hot grant, encoded index and slice-expiry pulse, feeding LED/status logic and downstream shared-resource muxes.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- SLICE_CYCLES, 150000000, maximum consecutive cycles per grant (3 s at 50 MHz); must be >= 1.
- CNT_W, 32, slice counter width; must satisfy 2^CNT_W > SLICE_CYCLES.
- Derived localparam IDX_W = max(1, clog2(NUM_REQ)).

Ports:
- clk  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- request_queue  input  NUM_REQ  request bit per requester; level-sensitive.
- grant_out  output  NUM_REQ  one-hot grant, or all-zero when idle.
- grant_valid  output  1  high when grant_out is nonzero.
- grant_idx  output  IDX_W  binary index of current owner; 0 when grant_valid=0.
- slice_expire  output  1  one-cycle pulse when a grant ended by quantum expiry.

Behaviour:
- Reset: one clock with reset=1 gives grant_out=0, grant_valid=0, grant_idx=0, slice_expire=0, internal ptr=0, counter=0, state IDLE. Reset dominates every other event, including mid-grant.
- Internal ptr is the highest-priority index for the next arbitration. Search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
- States: IDLE and GRANT.
- IDLE:
  - Any request bit set at edge k selects the winner by search order; grant_out, grant_idx and grant_valid are updated at edge k (visible in cycle k+1). Latency is 1 cycle.
  - Counter is cleared and the FSM moves to GRANT.
  - If there are no requests, it stays in IDLE with outputs 0.
- GRANT, at each edge:
  - release = (request_queue[owner]==0) OR (counter == SLICE_CYCLES-1).
  - If no release: counter += 1 and the owner is kept.
  - On release: ptr <= (owner+1) mod NUM_REQ, then re-arbitrate using the new ptr over the current request_queue in the same edge. Handoff is back-to-back, with no idle cycle.
  - If the owner is still requesting and is the only requester, it is re-granted with the counter cleared.
  - If no requests remain: go to IDLE and zero the outputs.
- slice_expire is registered and goes high for exactly one cycle in the cycle after the edge where the counter == SLICE_CYCLES-1 release occurred. It also pulses on self-re-grant. It does not pulse on a release caused by a request drop; request drop takes precedence if both happen at the same edge.
- SLICE_CYCLES=1: every grant lasts one cycle, giving pure per-cycle round robin. slice_expire is high every granted cycle.
- A request drop removes the grant one cycle later. grant_out may therefore be high for one cycle while the owner's request is low, and this is legal.
- Wrap-around: owner NUM_REQ-1 gives ptr=0.
- grant_out is never multi-hot. grant_idx always matches the set bit of grant_out.
- Counter never exceeds SLICE_CYCLES-1.

Optional Feature:
- Macro RR_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While grant_valid=1 and lock=1, quantum expiry is suppressed: the counter saturates at SLICE_CYCLES-1 and no slice_expire pulse is generated.
  - Owner request drop still releases the grant.
  - When lock falls with the counter saturated, release happens at the next edge with a slice_expire pulse.
- Undefined: no lock port exists, and behaviour is exactly as above.

Test Plan:
All scenarios use NUM_REQ=4 and SLICE_CYCLES=4.
1. Reset and idle:
   - Reset 3 cycles with request_queue=0000: all outputs 0.
   - Then request_queue=1111 with reset reasserted during grant 0100: outputs 0 the next cycle.
   - After reset releases: first grant is 0001.
2. request_queue=1111 held:
   - grant_out 0001×4, 0010×4, 0100×4, 1000×4, 0001…
   - grant_idx 0,1,2,3,0.
   - slice_expire pulses once every 4 cycles.
3. request_queue=1010 held:
   - Grants alternate 1000/0010 (order set by ptr), 4 cycles each.
   - Bits 0 and 2 are never granted, with no zero gaps between grants.
4. request_queue=0001 only:
   - grant_out stays 0001 continuously and grant_idx=0.
   - slice_expire pulses every 4th cycle.
5. Early release:
   - request_queue=1111, grant 0001 in cycle 1; drop bit 0 in cycle 2.
   - grant_out=0010 in cycle 3, held 4 full cycles.
   - No slice_expire at that handoff.
6. RR_ARB_LOCK_EN defined:
   - request_queue=1111, lock=1 for 10 cycles: grant 0001 held 10 cycles with no expire pulse.
   - Lock falls: at the next edge grant 0010 and slice_expire pulses.
